serial_frame_serializer: RTL and testbench

Parallel-in, serial-out (PISO) stage that sits directly upstream of the `000` Moore sequence detector and drives its serial input `x`. It accepts parallel words over a valid/ready handshake and shifts them out one bit per clock, MSB first. Frames go back-to-back with no idle gap. Between frames the line is held at a configurable idle level, which keeps the downstream detector from seeing false runs of zeros.

---
 rtl/serial_frame_serializer_pkg.sv | 23 ++
 rtl/serial_frame_serializer_if.sv | 25 ++
 rtl/serial_frame_serializer_bit_down_counter.sv | 40 ++++
 rtl/serial_frame_serializer.sv | 140 ++++++++++++++
 tb/tb_serial_frame_serializer.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/serial_frame_serializer_pkg.sv
// -----------------------------------------------------------------------------
// serializer_pkg
// Shared definitions for the serial frame serializer slice:
//   ser_state_t   : FSM state encoding {IDLE, SHIFT, PARITY}
//   SER_MAX_WIDTH : widest data word the serializer supports
//   odd_parity()  : odd parity over a zero-extended data word
// -----------------------------------------------------------------------------
package serializer_pkg;

  localparam int unsigned SER_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

  // Zero-extension does not change the XOR, so one function serves every WIDTH.
  function automatic logic odd_parity(input logic [SER_MAX_WIDTH-1:0] data);
    return ~(^data);
  endfunction

endpackage

// File: rtl/serial_frame_serializer_if.sv
// -----------------------------------------------------------------------------
// serial_frame_serializer_if
// Handshake and serial-output bundle of the serializer.
//   din, din_valid : parallel word and its valid (source -> serializer)
//   din_ready      : serializer can accept din this cycle
//   x, x_valid     : serial bit stream and its frame-bit qualifier
//   busy           : a frame is in progress
// Modports: master = word source / line consumer, slave = serializer.
// -----------------------------------------------------------------------------
interface serial_frame_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             x;
  logic             x_valid;
  logic             busy;

  modport master (output din, output din_valid,
                  input  din_ready, input x, input x_valid, input busy);

  modport slave  (input  din, input din_valid,
                  output din_ready, output x, output x_valid, output busy);
endinterface

// File: rtl/serial_frame_serializer_bit_down_counter.sv
// -----------------------------------------------------------------------------
// bit_down_counter
// Loadable down-counter tracking which bit of the frame is on the line.
//   clk, rst   : clock, asynchronous active-low reset (count -> 0)
//   load_i     : take load_val_i (has priority over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement by one
//   zero_o     : count is zero
// -----------------------------------------------------------------------------
module bit_down_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          dec_i,
  output logic          zero_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i)     count_d = load_val_i;
    else if (dec_i) count_d = count_q - CW'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/serial_frame_serializer.sv
// -----------------------------------------------------------------------------
// serial_frame_serializer
// Parallel-in, serial-out stage: accepts WIDTH-bit words over valid/ready and
// shifts them out MSB first on a registered line, frames back-to-back. Between
// frames the line rests at IDLE_LEVEL so a downstream zero-run detector never
// sees a false run.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset; aborts any frame in progress
//   bus : serial_frame_serializer_if.slave (din/din_valid/din_ready,
//         x/x_valid/busy)
// Build option: define SERIALIZER_PARITY_EN to append an odd-parity bit
// after the LSB of every frame (frame becomes WIDTH+1 bits).
// -----------------------------------------------------------------------------
module serial_frame_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input logic                      clk,
  input logic                      rst,
  serial_frame_serializer_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_SHIFT  = SHIFT;
`ifdef SERIALIZER_PARITY_EN
  localparam logic [1:0] S_PARITY = PARITY;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             x_q, x_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic             load;
  logic             finish;
`ifdef SERIALIZER_PARITY_EN
  logic             par_q, par_d;
`endif

  bit_down_counter #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (CW'(WIDTH - 1)),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Ready on idle or on the last bit of a frame, which is what lets frames
  // run back-to-back without a gap.
`ifdef SERIALIZER_PARITY_EN
  assign bus.din_ready = (state_q == S_IDLE) || (state_q == S_PARITY);
`else
  assign bus.din_ready = (state_q == S_IDLE) ||
                         ((state_q == S_SHIFT) && cnt_zero);
`endif

  assign load = bus.din_valid && bus.din_ready;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    x_d      = x_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    finish   = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    par_d    = par_q;
`endif

    case (state_q)
      S_SHIFT: begin
        if (!cnt_zero) begin
          // Register holds the already-emitted bit at the top; next one is below it.
          x_d     = shreg_q[WIDTH-2];
          shreg_d = shreg_q << 1;
          cnt_dec = 1'b1;
        end else begin
`ifdef SERIALIZER_PARITY_EN
          state_d = S_PARITY;
          x_d     = par_q;
`else
          finish  = 1'b1;
`endif
        end
      end
`ifdef SERIALIZER_PARITY_EN
      S_PARITY: finish = 1'b1;
`endif
      default: ;
    endcase

    if (finish) begin
      state_d = S_IDLE;
      x_d     = IDLE_LEVEL;
    end

    // A load on the final bit overrides the return to idle.
    if (load) begin
      state_d  = S_SHIFT;
      shreg_d  = bus.din;
      x_d      = bus.din[WIDTH-1];
      cnt_load = 1'b1;
`ifdef SERIALIZER_PARITY_EN
      par_d    = odd_parity(SER_MAX_WIDTH'(bus.din));
`endif
    end
  end

  // NOTE: the shift register is reset along with the control state so a
  // frame aborted by reset leaves no stale data behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      x_q     <= IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      x_q     <= x_d;
    end
  end

`ifdef SERIALIZER_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par_q <= 1'b0;
    else      par_q <= par_d;
  end
`endif

  assign bus.x       = x_q;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.x_valid = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_frame_serializer.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_serializer
// Directed bench for serial_frame_serializer (WIDTH=8, IDLE_LEVEL=1).
// Expected line bits are queued when a word is accepted and compared on the
// falling edge whenever x_valid is high; idle cycles check the idle level.
// -----------------------------------------------------------------------------
module tb_serial_frame_serializer;

  localparam int unsigned WIDTH = 8;
`ifdef SERIALIZER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  serial_frame_serializer_if #(.WIDTH(WIDTH)) bus ();

  serial_frame_serializer #(.WIDTH(WIDTH), .IDLE_LEVEL(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line monitor: every cycle, against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    check("busy_eq_x_valid", {31'b0, bus.busy}, {31'b0, bus.x_valid});
    if (bus.x_valid) begin
      if (sb.size() == 0) begin
        check("x_valid_unexpected", {31'b0, bus.x_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("x_bit", {31'b0, bus.x}, {31'b0, e.b});
        check("din_ready_frame", {31'b0, bus.din_ready}, {31'b0, e.last});
      end
    end else begin
      check("x_idle_level", {31'b0, bus.x}, 32'd1);
      check("din_ready_idle", {31'b0, bus.din_ready}, 32'd1);
      check("no_pending_bits_idle", sb.size(), 32'd0);
    end
  end

  task automatic push_word(input logic [WIDTH-1:0] w);
    for (int i = WIDTH - 1; i >= 0; i--)
      sb.push_back('{b: w[i], last: (!PAR && i == 0)});
    if (PAR) sb.push_back('{b: ~(^w), last: 1'b1});
  endtask

  // Present a word, wait (bounded) for acceptance, queue its expected bits.
  task automatic send(input logic [WIDTH-1:0] w, input bit hold);
    bit accepted = 1'b0;
    @(posedge clk); #1;
    bus.din       = w;
    bus.din_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.din_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    check("load_timeout", {31'b0, accepted}, 32'd1);
    @(posedge clk); #1;
    if (accepted) push_word(w);
    if (!hold) bus.din_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk); #1;
      if (sb.size() == 0 && !bus.x_valid) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_timeout", {31'b0, done}, 32'd1);
  endtask

  initial begin
    // Reset with a word pending: nothing may load.
    bus.din       = 8'hFF;
    bus.din_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_x", {31'b0, bus.x}, 32'd1);
    check("reset_x_valid", {31'b0, bus.x_valid}, 32'd0);
    check("reset_din_ready", {31'b0, bus.din_ready}, 32'd1);
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("post_reset_no_load", {31'b0, bus.x_valid}, 32'd0);

    // Single frame with a zero run for the detector.
    send(8'b1000_1000, 1'b0);
    wait_drain();
    check("single_idle_x", {31'b0, bus.x}, 32'd1);

    // Back-to-back frames with valid held.
    send(8'hA5, 1'b1);
    send(8'h3C, 1'b0);
    wait_drain();

    // Parity pattern (plain 8-bit frame in the default build).
    send(8'h07, 1'b0);
    wait_drain();

    // Idle hold with valid low.
    repeat (5) @(negedge clk);

    // Stall: valid pulse mid-frame must be ignored.
    send(8'h5A, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    bus.din       = 8'hFF;
    bus.din_valid = 1'b1;
    check("stall_ready_low", {31'b0, bus.din_ready}, 32'd0);
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
    wait_drain();

    // Reset mid-frame: asynchronous abort, then a clean frame.
    send(8'h0F, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    sb.delete();
    check("abort_x", {31'b0, bus.x}, 32'd1);
    check("abort_x_valid", {31'b0, bus.x_valid}, 32'd0);
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_din_ready", {31'b0, bus.din_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    send(8'hF0, 1'b0);
    wait_drain();

    repeat (3) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
